// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32 subset core:
// sequencer states, reset/halt encodings and ALU operation codes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seq_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] HALT_INSN_DEFAULT = 32'h0000_0073;
  localparam logic [31:0] PC_STEP           = 32'd4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_EQ   = 4'd10
  } alu_op_e;

endpackage

// File: rtl/npc_sel.sv
// Next-PC selection: jal beats jalr, jalr beats a taken branch,
// everything else falls through to pc+4. Sums wrap modulo 2^32.
module npc_sel (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        jal_en,
  input  logic        jalr_en,
  input  logic        branch_en,
  output logic [31:0] next_pc
);
  import core_pkg::*;

  // Priority mux over the jump/branch sources
  always_comb begin
    next_pc = pc + PC_STEP;
    if (jal_en) begin
      next_pc = pc + imm;
    end else if (jalr_en) begin
      next_pc = {alu_result[31:1], 1'b0};
    end else if (branch_en && alu_result[0]) begin
      next_pc = pc + imm;
    end else begin
      next_pc = pc + PC_STEP;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM. All outputs come
// straight from flops; the flag outputs are decoded from the next state.
module core_sequencer #(
  parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] HALT_INSN = core_pkg::HALT_INSN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] insn,
  input  logic        branch_en,
  input  logic        jal_en,
  input  logic        jalr_en,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic        reg_we,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted
);
  import core_pkg::*;

  seq_state_e  r_state;
  seq_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_insn;
  logic [31:0] r_next_pc;
  logic [31:0] r_dmem_addr;
  logic [31:0] w_npc;
  logic        r_is_store;
  logic        r_wr_pend;
  logic        r_imem_req, r_dmem_req, r_dmem_we, r_rf_we, r_busy, r_halted;
  logic        w_imem_req_nxt, w_dmem_req_nxt, w_dmem_we_nxt;
  logic        w_rf_we_nxt, w_busy_nxt, w_halted_nxt;

  npc_sel u_npc_sel (
    .pc         (r_pc),
    .imm        (imm),
    .alu_result (alu_result),
    .jal_en     (jal_en),
    .jalr_en    (jalr_en),
    .branch_en  (branch_en),
    .next_pc    (w_npc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; acks only count in the state that owns the request
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        if (start) w_state_nxt = ST_FETCH;
        else       w_state_nxt = r_state;
      end
      ST_FETCH: begin
        if (!imem_ack)                    w_state_nxt = ST_FETCH;
        else if (imem_rdata == HALT_INSN) w_state_nxt = ST_HALT;
        else                              w_state_nxt = ST_DECODE;
      end
      ST_DECODE: w_state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (mem_re || mem_we) w_state_nxt = ST_MEM;
        else                  w_state_nxt = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ack) w_state_nxt = ST_WB;
        else          w_state_nxt = ST_MEM;
      end
      ST_WB:   w_state_nxt = ST_FETCH;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output flags for the coming state; store/write intent is taken live in EXEC
  always_comb begin
    w_imem_req_nxt = (w_state_nxt == ST_FETCH);
    w_dmem_req_nxt = (w_state_nxt == ST_MEM);
    w_busy_nxt     = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_HALT);
    w_halted_nxt   = (w_state_nxt == ST_HALT);
    w_dmem_we_nxt  = 1'b0;
    w_rf_we_nxt    = 1'b0;
    if (r_state == ST_EXEC) begin
      w_dmem_we_nxt = w_dmem_req_nxt && mem_we;
      w_rf_we_nxt   = (w_state_nxt == ST_WB) && reg_we && !mem_we;
    end else begin
      w_dmem_we_nxt = w_dmem_req_nxt && r_is_store;
      w_rf_we_nxt   = (w_state_nxt == ST_WB) && r_wr_pend;
    end
  end

  // Registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_imem_req <= w_imem_req_nxt;
      r_dmem_req <= w_dmem_req_nxt;
      r_dmem_we  <= w_dmem_we_nxt;
      r_rf_we    <= w_rf_we_nxt;
      r_busy     <= w_busy_nxt;
      r_halted   <= w_halted_nxt;
    end
  end

  // PC, instruction register and EXEC-stage latches
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_insn      <= 32'h0000_0000;
      r_next_pc   <= 32'h0000_0000;
      r_dmem_addr <= 32'h0000_0000;
      r_is_store  <= 1'b0;
      r_wr_pend   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_HALT: if (start) r_pc <= RESET_PC;
        ST_FETCH:         if (imem_ack) r_insn <= imem_rdata;
        ST_EXEC: begin
          r_next_pc   <= w_npc;
          r_dmem_addr <= alu_result;
          r_is_store  <= mem_we;
          r_wr_pend   <= reg_we && !mem_we;
        end
        ST_WB:   r_pc <= r_next_pc;
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_pc;
  assign insn      = r_insn;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign dmem_addr = r_dmem_addr;
  assign rf_we     = r_rf_we;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: a hand-computed vector table, hand-written
// reset/halt/restart sequences, and random instructions against a rule model.
module tb_core_sequencer;

  localparam logic [31:0] HALT = 32'h0000_0073;

  logic        clk = 1'b0;
  logic        reset, start, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic        branch_en, jal_en, jalr_en, mem_re, mem_we, reg_we, rf_we, busy, halted;
  logic [31:0] imem_addr, imem_rdata, insn, imm, alu_result, dmem_addr, pc;

  int errors = 0;
  int checks = 0;

  core_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .insn(insn), .branch_en(branch_en), .jal_en(jal_en), .jalr_en(jalr_en),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .imm(imm), .alu_result(alu_result),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .busy(busy), .halted(halted)
  );

  always #5 clk = ~clk;

  // ctl = {jal, jalr, branch, mem_re, mem_we, reg_we}
  typedef struct {
    logic [31:0] rdata;
    logic [5:0]  ctl;
    logic [31:0] imm;
    logic [31:0] alu;
    int          iwait;
    int          dwait;
    int          start_cyc;
    logic [31:0] e_pc;
    int          e_cyc;
    int          e_rf;
    int          e_dreq;
    logic        e_dwe;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] rdata, input logic [5:0] ctl,
                              input logic [31:0] imm_v, input logic [31:0] alu,
                              input int iwait, input int dwait, input int start_cyc,
                              input logic [31:0] e_pc, input int e_cyc, input int e_rf,
                              input int e_dreq, input logic e_dwe, input logic e_halt);
    vec_t v;
    v.rdata = rdata; v.ctl = ctl; v.imm = imm_v; v.alu = alu;
    v.iwait = iwait; v.dwait = dwait; v.start_cyc = start_cyc;
    v.e_pc = e_pc; v.e_cyc = e_cyc; v.e_rf = e_rf; v.e_dreq = e_dreq;
    v.e_dwe = e_dwe; v.e_halt = e_halt;
    return v;
  endfunction

  // Reference: expected outcome of one instruction started at address cur_pc
  function automatic vec_t model(input vec_t v, input logic [31:0] cur_pc);
    vec_t r = v;
    bit jal = v.ctl[5], jalr = v.ctl[4], br = v.ctl[3];
    bit re = v.ctl[2], we = v.ctl[1], rwe = v.ctl[0];
    bit mem = re || we;
    if (v.rdata == HALT) begin
      r.e_halt = 1'b1; r.e_pc = cur_pc; r.e_cyc = v.iwait + 1;
      r.e_rf = 0; r.e_dreq = 0; r.e_dwe = 1'b0;
    end else begin
      r.e_halt = 1'b0;
      if (jal)                r.e_pc = cur_pc + v.imm;
      else if (jalr)          r.e_pc = v.alu & 32'hFFFF_FFFE;
      else if (br && v.alu[0]) r.e_pc = cur_pc + v.imm;
      else                    r.e_pc = cur_pc + 32'd4;
      r.e_cyc  = 4 + v.iwait + (mem ? 1 + v.dwait : 0);
      r.e_rf   = (rwe && !we) ? 1 : 0;
      r.e_dreq = mem ? 1 + v.dwait : 0;
      r.e_dwe  = we;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk($sformatf("%s imem_req", tag), imem_req, 0);
    chk($sformatf("%s dmem_req", tag), dmem_req, 0);
    chk($sformatf("%s dmem_we", tag), dmem_we, 0);
    chk($sformatf("%s rf_we", tag), rf_we, 0);
    chk($sformatf("%s busy", tag), busy, 0);
    chk($sformatf("%s halted", tag), halted, 0);
    chk($sformatf("%s pc", tag), pc, 32'h0);
    chk($sformatf("%s imem_addr", tag), imem_addr, 32'h0);
    chk($sformatf("%s insn", tag), insn, 32'h0);
    chk($sformatf("%s dmem_addr", tag), dmem_addr, 32'h0);
  endtask

  // All helpers below begin and end at a falling edge
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs one instruction from its first FETCH cycle until the next FETCH (or HALT)
  task automatic run_insn(input vec_t v, input bit stray, input string tag);
    int cyc = 0, iw = 0, dw = 0, rf = 0, rf_cyc = 0, dreq = 0, k = 0;
    bit fetched = 0, done = 0, dwe_seen = 0, busy1 = 0;
    logic [31:0] daddr = 32'h0;
    {jal_en, jalr_en, branch_en, mem_re, mem_we, reg_we} = v.ctl;
    imm = v.imm; alu_result = v.alu; imem_rdata = v.rdata;
    while (!done && k < 64) begin
      cyc++;
      if (cyc == 1) busy1 = busy;
      if (rf_we) begin rf++; rf_cyc = cyc; end
      if (dmem_req) begin dreq++; dwe_seen |= dmem_we; daddr = dmem_addr; end
      start = (v.start_cyc == cyc);
      if (imem_req) begin
        imem_ack = (iw == v.iwait);
        if (imem_ack) fetched = 1;
        iw++;
      end else begin
        imem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (dmem_req) begin
        dmem_ack = (dw == v.dwait);
        dw++;
      end else begin
        dmem_ack = stray ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      @(negedge clk);
      if (fetched && (imem_req || halted)) done = 1;
      k++;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0; start = 1'b0;
    chk($sformatf("%s completes", tag), done, 1);
    chk($sformatf("%s busy in fetch", tag), busy1, 1);
    chk($sformatf("%s cycles", tag), cyc, v.e_cyc);
    chk($sformatf("%s pc", tag), pc, v.e_pc);
    chk($sformatf("%s imem_addr", tag), imem_addr, v.e_pc);
    chk($sformatf("%s rf_we cycles", tag), rf, v.e_rf);
    if (v.e_rf != 0) chk($sformatf("%s rf_we in last cycle", tag), rf_cyc, v.e_cyc);
    chk($sformatf("%s dmem_req cycles", tag), dreq, v.e_dreq);
    chk($sformatf("%s dmem_we", tag), dwe_seen, v.e_dwe);
    if (v.e_dreq != 0) chk($sformatf("%s dmem_addr in mem", tag), daddr, v.alu);
    chk($sformatf("%s insn", tag), insn, v.rdata);
    chk($sformatf("%s halted", tag), halted, v.e_halt);
    chk($sformatf("%s busy", tag), busy, !v.e_halt);
    chk($sformatf("%s imem_req", tag), imem_req, !v.e_halt);
    if (!v.e_halt) chk($sformatf("%s dmem_addr held", tag), dmem_addr, v.alu);
  endtask

  vec_t tbl[16];
  vec_t rv;
  logic [31:0] mpc;

  initial begin
    reset = 1'b1; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    imem_rdata = 32'h0; imm = 32'h0; alu_result = 32'h0;
    {jal_en, jalr_en, branch_en, mem_re, mem_we, reg_we} = 6'b000000;

    //          rdata          ctl        imm            alu            iw dw st  e_pc           cyc rf dreq dwe halt
    tbl[0]  = mk(32'h00500093, 6'b000001, 32'h00000005, 32'h00000005, 0, 0, 0, 32'h00000004, 4, 1, 0, 1'b0, 1'b0);
    tbl[1]  = mk(32'h00000463, 6'b001000, 32'h00000008, 32'h00000001, 0, 0, 0, 32'h00000008, 4, 0, 0, 1'b0, 1'b0);
    tbl[2]  = mk(32'h00000463, 6'b001000, 32'h00000008, 32'h00000000, 0, 0, 0, 32'h00000004, 4, 0, 0, 1'b0, 1'b0);
    tbl[3]  = mk(32'h000080e7, 6'b010001, 32'h00000000, 32'h00000103, 0, 0, 0, 32'h00000102, 4, 1, 0, 1'b0, 1'b0);
    tbl[4]  = mk(32'h008000ef, 6'b111001, 32'h00000010, 32'h00000054, 0, 0, 0, 32'h00000010, 4, 1, 0, 1'b0, 1'b0);
    tbl[5]  = mk(32'h000080e7, 6'b011001, 32'h00000020, 32'h00000201, 0, 0, 0, 32'h00000200, 4, 1, 0, 1'b0, 1'b0);
    tbl[6]  = mk(32'h0000a103, 6'b000101, 32'h00000000, 32'h00000040, 0, 3, 0, 32'h00000004, 8, 1, 4, 1'b0, 1'b0);
    tbl[7]  = mk(32'h0020a023, 6'b000011, 32'h00000000, 32'h00000080, 0, 0, 0, 32'h00000004, 5, 0, 1, 1'b1, 1'b0);
    tbl[8]  = mk(32'h0020a023, 6'b000111, 32'h00000000, 32'h00000084, 0, 1, 0, 32'h00000004, 6, 0, 2, 1'b1, 1'b0);
    tbl[9]  = mk(32'h0000000b, 6'b000000, 32'h00000100, 32'h00000001, 0, 0, 0, 32'h00000004, 4, 0, 0, 1'b0, 1'b0);
    tbl[10] = mk(32'h00500093, 6'b000001, 32'h00000005, 32'h00000005, 2, 0, 0, 32'h00000004, 6, 1, 0, 1'b0, 1'b0);
    tbl[11] = mk(32'h00000463, 6'b001000, 32'hFFFFFFF8, 32'h00000001, 0, 0, 0, 32'hFFFFFFF8, 4, 0, 0, 1'b0, 1'b0);
    tbl[12] = mk(32'h00008067, 6'b010000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 4, 0, 0, 1'b0, 1'b0);
    tbl[13] = mk(32'h00500093, 6'b000001, 32'h00000005, 32'h00000005, 0, 0, 3, 32'h00000004, 4, 1, 0, 1'b0, 1'b0);
    tbl[14] = mk(32'h00500093, 6'b000001, 32'h00000005, 32'h00000005, 2, 0, 1, 32'h00000004, 6, 1, 0, 1'b0, 1'b0);
    tbl[15] = mk(HALT,         6'b000000, 32'h00000000, 32'h00000077, 0, 0, 0, 32'h00000000, 1, 0, 0, 1'b0, 1'b1);

    @(negedge clk);
    do_reset();
    chk_reset_vals("por");
    repeat (2) @(negedge clk);
    chk("idle without start busy", busy, 0);

    foreach (tbl[i]) begin
      do_reset();
      do_start();
      run_insn(tbl[i], 1'b0, $sformatf("vec%0d", i));
    end

    // HALT at a non-zero PC holds that PC; stray acks while halted change nothing
    do_reset();
    do_start();
    run_insn(tbl[0], 1'b0, "pre_halt");
    run_insn(model(mk(HALT, 6'b000000, 32'h0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 1'b0, 1'b0),
                   32'h4), 1'b0, "halt_at4");
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("halt hold pc", pc, 32'h4);
    chk("halt hold halted", halted, 1);
    do_start();
    chk("restart pc", pc, 32'h0);
    chk("restart imem_req", imem_req, 1);
    chk("restart halted", halted, 0);
    chk("restart busy", busy, 1);

    // Reset during MEM with an ack pending: everything back to reset values
    do_reset();
    do_start();
    run_insn(tbl[0], 1'b0, "pre_mem");
    {jal_en, jalr_en, branch_en, mem_re, mem_we, reg_we} = 6'b000101;
    imem_rdata = 32'h0000a103; alu_result = 32'h40; imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid mem dmem_req", dmem_req, 1);
    reset = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    chk_reset_vals("mem_reset");
    reset = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("after mem_reset busy", busy, 0);
    chk("after mem_reset rf_we", rf_we, 0);
    chk("after mem_reset dmem_req", dmem_req, 0);

    // Random instructions with stray acks and start pulses while busy
    do_reset();
    do_start();
    mpc = 32'h0;
    for (int n = 0; n < 200; n++) begin
      rv.rdata = $urandom;
      if (rv.rdata == HALT) rv.rdata = rv.rdata ^ 32'h1;
      if ($urandom_range(0, 19) == 0) rv.rdata = HALT;
      rv.ctl = 6'($urandom_range(0, 63));
      rv.imm = $urandom;
      rv.alu = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 3));
      rv.iwait = $urandom_range(0, 2);
      rv.dwait = $urandom_range(0, 3);
      rv.start_cyc = (rv.rdata == HALT) ? 0 : $urandom_range(0, 4);
      rv = model(rv, mpc);
      run_insn(rv, 1'b1, $sformatf("rnd%0d", n));
      mpc = rv.e_pc;
      if (rv.e_halt) begin
        do_start();
        mpc = 32'h0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
